// File: rtl/cpu_scoreboard_if.sv
// Decode-to-scoreboard handshake: issue request, bypass select, writeback and flush.
interface cpu_scoreboard_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned NSRC  = 3,
  parameter int unsigned LAT_W = 3
);
  logic                 issue_valid;
  logic                 issue_ready;
  logic [NSRC-1:0]      issue_src_en;
  logic [NSRC*AW-1:0]   issue_src;
  logic                 issue_dst_en;
  logic [AW-1:0]        issue_dst;
  logic [LAT_W-1:0]     issue_lat;
  logic [NSRC-1:0]      src_fwd;
  logic                 wb_valid;
  logic [AW-1:0]        wb_dst;
  logic                 flush;

  modport master (
    output issue_valid, issue_src_en, issue_src, issue_dst_en, issue_dst, issue_lat,
    output wb_valid, wb_dst, flush,
    input  issue_ready, src_fwd
  );

  modport slave (
    input  issue_valid, issue_src_en, issue_src, issue_dst_en, issue_dst, issue_lat,
    input  wb_valid, wb_dst, flush,
    output issue_ready, src_fwd
  );
endinterface

// File: rtl/cpu_scoreboard.sv
// Per-register scoreboard: busy/countdown/age tracking for issue stall,
// bypass selection and speculative-entry cleanup on flush.
module cpu_scoreboard #(
  parameter int unsigned NREG      = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned NSRC      = 3,
  parameter int unsigned LAT_W     = 3,
  parameter int unsigned FLUSH_AGE = 2,
  parameter bit          ZERO_REG  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  cpu_scoreboard_if.slave bus,
  output logic [AW:0]    busy_cnt,
  output logic [31:0]    stall_cnt
);

  localparam int unsigned AGE_W = (FLUSH_AGE < 1) ? 1 : $clog2(FLUSH_AGE + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(FLUSH_AGE);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [LAT_W-1:0] rem_q [NREG];
  logic [LAT_W-1:0] rem_d [NREG];
  logic [AGE_W-1:0] age_q [NREG];
  logic [AGE_W-1:0] age_d [NREG];
  logic [AW:0]      cnt_d;

  logic            raw_stall;
  logic            waw_stall;
  logic [NSRC-1:0] fwd;
  logic            ready;
  logic            fire;

  // Hazard lookup against current state; a same-cycle writeback frees the destination.
  always_comb begin
    raw_stall = 1'b0;
    waw_stall = 1'b0;
    fwd       = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int j = 0; j < NREG; j++) begin
        if (bus.issue_src_en[i] && bus.issue_src[i*AW +: AW] == AW'(j) &&
            !(ZERO_REG && j == 0) && busy_q[j]) begin
          if (rem_q[j] != '0) raw_stall = 1'b1;
          else                fwd[i]    = 1'b1;
        end
      end
    end
    for (int j = 0; j < NREG; j++) begin
      if (bus.issue_dst_en && bus.issue_dst == AW'(j) && busy_q[j] &&
          !(bus.wb_valid && bus.wb_dst == AW'(j)))
        waw_stall = 1'b1;
    end
  end

  assign ready           = !bus.flush && !raw_stall && !waw_stall;
  assign fire            = bus.issue_valid && ready;
  assign bus.issue_ready = ready;
  assign bus.src_fwd     = fwd & {NSRC{bus.issue_valid}};

  // Entry update priority: age/countdown < flush kill < writeback clear < new issue.
  always_comb begin
    cnt_d = '0;
    for (int j = 0; j < NREG; j++) begin
      busy_d[j] = busy_q[j];
      rem_d[j]  = rem_q[j];
      age_d[j]  = age_q[j];
      if (busy_q[j]) begin
        if (rem_q[j] != '0)    rem_d[j] = rem_q[j] - LAT_W'(1);
        if (age_q[j] < AGE_MAX) age_d[j] = age_q[j] + AGE_W'(1);
      end
      if (bus.flush && busy_q[j] && age_q[j] < AGE_MAX) begin
        busy_d[j] = 1'b0;
        rem_d[j]  = '0;
        age_d[j]  = AGE_MAX;
      end
      if (bus.wb_valid && bus.wb_dst == AW'(j)) begin
        busy_d[j] = 1'b0;
        rem_d[j]  = '0;
        age_d[j]  = AGE_MAX;
      end
      if (fire && bus.issue_dst_en && bus.issue_dst == AW'(j) && !(ZERO_REG && j == 0)) begin
        busy_d[j] = 1'b1;
        rem_d[j]  = (bus.issue_lat == '0) ? '0 : bus.issue_lat - LAT_W'(1);
        age_d[j]  = '0;
      end
      cnt_d = cnt_d + (AW+1)'(busy_d[j]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      busy_cnt  <= '0;
      stall_cnt <= '0;
      for (int j = 0; j < NREG; j++) begin
        rem_q[j] <= '0;
        age_q[j] <= AGE_MAX;
      end
    end else begin
      busy_q   <= busy_d;
      busy_cnt <= cnt_d;
      for (int j = 0; j < NREG; j++) begin
        rem_q[j] <= rem_d[j];
        age_q[j] <= age_d[j];
      end
      if (bus.issue_valid && !ready && !bus.flush)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_scoreboard.sv
// Directed bench for cpu_scoreboard in the 64-entry int+fp configuration.
module tb_cpu_scoreboard;
  localparam int unsigned NREG  = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned NSRC  = 3;
  localparam int unsigned LAT_W = 3;

  logic        clk;
  logic        rst;
  logic [AW:0] busy_cnt;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  cpu_scoreboard_if #(.AW(AW), .NSRC(NSRC), .LAT_W(LAT_W)) bus ();

  cpu_scoreboard #(
    .NREG(NREG), .AW(AW), .NSRC(NSRC), .LAT_W(LAT_W), .FLUSH_AGE(2), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .busy_cnt(busy_cnt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sen, input logic [AW-1:0] s0,
                       input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic den,
                       input logic [AW-1:0] d, input logic [LAT_W-1:0] lat);
    bus.issue_valid  = v;
    bus.issue_src_en = sen;
    bus.issue_src    = {s2, s1, s0};
    bus.issue_dst_en = den;
    bus.issue_dst    = d;
    bus.issue_lat    = lat;
    #1;
  endtask

  task automatic idle();
    bus.wb_valid = 1'b0;
    bus.wb_dst   = '0;
    bus.flush    = 1'b0;
    drive(1'b0, 3'b000, '0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    chk("rst_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_fwd", 64'(bus.src_fwd), 64'd0);
    chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // ALU result (lat 1) forwards back-to-back
    drive(1'b1, 3'b000, '0, '0, '0, 1'b1, 6'd5, 3'd1);
    chk("alu_issue_ready", 64'(bus.issue_ready), 64'd1);
    tick();
    drive(1'b1, 3'b001, 6'd5, '0, '0, 1'b0, '0, 3'd1);
    chk("alu_dep_ready", 64'(bus.issue_ready), 64'd1);
    chk("alu_dep_fwd", 64'(bus.src_fwd), 64'b001);
    chk("alu_busy_cnt", 64'(busy_cnt), 64'd1);
    tick();
    idle();
    bus.wb_valid = 1'b1; bus.wb_dst = 6'd5;
    tick();
    idle();
    chk("alu_wb_busy_cnt", 64'(busy_cnt), 64'd0);

    // Load-use: exactly one stall
    drive(1'b1, 3'b000, '0, '0, '0, 1'b1, 6'd7, 3'd2);
    tick();
    drive(1'b1, 3'b001, 6'd7, '0, '0, 1'b0, '0, 3'd1);
    chk("ld_use_stall", 64'(bus.issue_ready), 64'd0);
    chk("ld_use_nofwd", 64'(bus.src_fwd), 64'd0);
    tick();
    chk("ld_use_stall_cnt", 64'(stall_cnt), 64'd1);
    chk("ld_use_ready", 64'(bus.issue_ready), 64'd1);
    chk("ld_use_fwd", 64'(bus.src_fwd), 64'b001);
    tick();
    idle();
    bus.wb_valid = 1'b1; bus.wb_dst = 6'd7;
    tick();
    idle();
    chk("ld_wb_busy_cnt", 64'(busy_cnt), 64'd0);

    // WAW on r3 until writeback; re-arm in the wb cycle
    drive(1'b1, 3'b000, '0, '0, '0, 1'b1, 6'd3, 3'd1);
    tick();
    chk("waw_busy_cnt", 64'(busy_cnt), 64'd1);
    drive(1'b1, 3'b000, '0, '0, '0, 1'b1, 6'd3, 3'd1);
    chk("waw_stall", 64'(bus.issue_ready), 64'd0);
    tick();
    chk("waw_stall_cnt", 64'(stall_cnt), 64'd2);
    bus.wb_valid = 1'b1; bus.wb_dst = 6'd3;
    #1;
    chk("waw_wb_ready", 64'(bus.issue_ready), 64'd1);
    tick();
    idle();
    chk("waw_rearm_busy_cnt", 64'(busy_cnt), 64'd1);
    chk("waw_rearm_stall_cnt", 64'(stall_cnt), 64'd2);
    bus.flush = 1'b1;
    #1;
    chk("flush_ready", 64'(bus.issue_ready), 64'd0);
    tick();
    idle();
    chk("waw_rearm_age0_killed", 64'(busy_cnt), 64'd0);

    // Flush kills young r9, keeps old r10
    drive(1'b1, 3'b000, '0, '0, '0, 1'b1, 6'd10, 3'd1);
    tick();
    idle();
    tick();
    tick();
    drive(1'b1, 3'b000, '0, '0, '0, 1'b1, 6'd9, 3'd1);
    tick();
    chk("pre_flush_busy_cnt", 64'(busy_cnt), 64'd2);
    bus.flush = 1'b1;
    drive(1'b1, 3'b000, '0, '0, '0, 1'b1, 6'd12, 3'd1);
    chk("flush_blocks_issue", 64'(bus.issue_ready), 64'd0);
    tick();
    idle();
    chk("post_flush_busy_cnt", 64'(busy_cnt), 64'd1);
    chk("flush_no_stall_count", 64'(stall_cnt), 64'd2);
    drive(1'b1, 3'b000, '0, '0, '0, 1'b1, 6'd10, 3'd1);
    chk("r10_kept_waw", 64'(bus.issue_ready), 64'd0);
    idle();
    bus.wb_valid = 1'b1; bus.wb_dst = 6'd10;
    tick();
    idle();
    chk("r10_wb_busy_cnt", 64'(busy_cnt), 64'd0);

    // Hardwired r0
    drive(1'b1, 3'b000, '0, '0, '0, 1'b1, 6'd0, 3'd4);
    tick();
    chk("r0_busy_cnt", 64'(busy_cnt), 64'd0);
    drive(1'b1, 3'b001, 6'd0, '0, '0, 1'b0, '0, 3'd1);
    chk("r0_ready", 64'(bus.issue_ready), 64'd1);
    chk("r0_fwd", 64'(bus.src_fwd), 64'd0);
    tick();
    idle();

    // Latency 7 on FP r40, three dependent sources
    drive(1'b1, 3'b000, '0, '0, '0, 1'b1, 6'd40, 3'd7);
    tick();
    drive(1'b1, 3'b111, 6'd40, 6'd40, 6'd40, 1'b0, '0, 3'd1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("lat7_stall_%0d", k), 64'(bus.issue_ready), 64'd0);
      tick();
    end
    chk("lat7_ready", 64'(bus.issue_ready), 64'd1);
    chk("lat7_fwd", 64'(bus.src_fwd), 64'b111);
    chk("lat7_stall_cnt", 64'(stall_cnt), 64'd8);
    tick();
    idle();
    chk("lat7_busy_cnt", 64'(busy_cnt), 64'd1);

    // Asynchronous reset mid-operation
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy_cnt", 64'(busy_cnt), 64'd0);
    chk("async_rst_stall_cnt", 64'(stall_cnt), 64'd0);
    drive(1'b1, 3'b001, 6'd40, '0, '0, 1'b0, '0, 3'd1);
    chk("async_rst_r40_free", 64'(bus.issue_ready), 64'd1);
    idle();
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
